// File: rtl/train_timer_if.sv
// Bundle of the controller-facing signals of the phase timer.
// The timer takes the slave side; the controller/selector side drives master.
interface train_timer_if #(
    parameter int TIME_W  = 13,
    parameter int STATE_W = 4
);
    logic [STATE_W-1:0] present_state;
    logic [TIME_W-1:0]  tload;
    logic               pause;
    logic [TIME_W-1:0]  remaining;
    logic               busy;
    logic               expired;

    modport master (
        output present_state, tload, pause,
        input  remaining, busy, expired
    );

    modport slave (
        input  present_state, tload, pause,
        output remaining, busy, expired
    );
endinterface

// File: rtl/train_timer.sv
// Phase countdown timer for the train controller: restarts on every controller state change.
// Optional macro TRAIN_TIMER_AUTORELOAD_EN re-arms the same duration instead of holding in DONE.
//
// state | meaning
// IDLE  | one cycle after reset, treated as a phase entry
// ARM   | one cycle waiting for the selector's registered duration
// RUN   | prescaler counting, remaining decrements once per time unit
// DONE  | phase elapsed, remaining=0, waiting for a state change
module train_timer #(
    parameter int          TIME_W   = 13,
    parameter int          STATE_W  = 4,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic         clk,
    input  logic         rst,
    train_timer_if.slave bus
);
    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [TIME_W-1:0]  remaining_q, remaining_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               expired_q, expired_d;
    logic [STATE_W-1:0] state_q;
    logic               chg;
    logic               tick;

    assign chg  = (bus.present_state != state_q);
    assign tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            remaining_q <= '0;
            presc_q     <= '0;
            expired_q   <= 1'b0;
            state_q     <= '0;
        end else begin
            fsm_q       <= fsm_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            expired_q   <= expired_d;
            state_q     <= bus.present_state;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        expired_d   = 1'b0;
        case (fsm_q)
            IDLE: fsm_d = ARM;
            ARM: begin
                presc_d = '0;
                // A further state change keeps us in ARM for the newer duration.
                if (!chg) begin
                    remaining_d = bus.tload;
                    if (bus.tload == '0) begin
                        fsm_d     = DONE;
                        expired_d = 1'b1;
                    end else begin
                        fsm_d = RUN;
                    end
                end
            end
            RUN: begin
                if (chg) begin
                    fsm_d   = ARM;
                    presc_d = '0;
                end else if (!bus.pause) begin
                    if (tick) begin
                        presc_d = '0;
                        if (remaining_q != '0) begin
                            remaining_d = remaining_q - TIME_W'(1);
                        end
                        if (remaining_q == TIME_W'(1)) begin
                            expired_d = 1'b1;
`ifdef TRAIN_TIMER_AUTORELOAD_EN
                            fsm_d = ARM;
`else
                            fsm_d = DONE;
`endif
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
            end
            DONE: begin
                presc_d = '0;
`ifdef TRAIN_TIMER_AUTORELOAD_EN
                fsm_d = ARM;
`else
                if (chg) begin
                    fsm_d = ARM;
                end
`endif
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign bus.remaining = remaining_q;
    assign bus.busy      = (fsm_q == ARM) || (fsm_q == RUN);
    assign bus.expired   = expired_q;
endmodule

// File: tb/tb_train_timer.sv
// Self-checking bench for train_timer: two instances (TICK_DIV 4 and 2) share clock and reset.
// Expected expiry cycles are queued when stimulus is applied and matched against observed pulses.
module tb_train_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    train_timer_if #(.TIME_W(13), .STATE_W(4)) bus_a ();
    train_timer_if #(.TIME_W(13), .STATE_W(4)) bus_b ();

    train_timer #(.TIME_W(13), .STATE_W(4), .TICK_DIV(4)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    train_timer #(.TIME_W(13), .STATE_W(4), .TICK_DIV(2)) u_b (.clk(clk), .rst(rst), .bus(bus_b));

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int qa[$];
    int qb[$];
    int ea, eb;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus_a.expired === 1'b1) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_bad++;
                $display("FAIL expired_a: unexpected pulse at cycle %0d, none required", cyc);
            end else begin
                ea = qa.pop_front();
                if (cyc !== ea) begin
                    n_bad++;
                    $display("FAIL expired_a: pulse at cycle %0d, required at %0d", cyc, ea);
                end
            end
        end
        if (bus_b.expired === 1'b1) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_bad++;
                $display("FAIL expired_b: unexpected pulse at cycle %0d, none required", cyc);
            end else begin
                eb = qb.pop_front();
                if (cyc !== eb) begin
                    n_bad++;
                    $display("FAIL expired_b: pulse at cycle %0d, required at %0d", cyc, eb);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int left;
        left = budget;
        while ((qa.size() != 0 || qb.size() != 0) && left > 0) begin
            step(1);
            left--;
        end
        step(2);
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending a=%0d b=%0d, required 0/0", qa.size(), qb.size());
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.present_state = 4'd0; bus_a.tload = 13'd3; bus_a.pause = 1'b0;
        bus_b.present_state = 4'd0; bus_b.tload = 13'd4; bus_b.pause = 1'b0;
        step(3);
        n_cmp++; if (bus_a.remaining !== 13'd0) begin n_bad++; $display("FAIL reset_rem_a: got %0d required 0", bus_a.remaining); end
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_a: got %b required 0", bus_a.busy); end
        n_cmp++; if (bus_a.expired !== 1'b0) begin n_bad++; $display("FAIL reset_exp_a: got %b required 0", bus_a.expired); end
        n_cmp++; if (bus_b.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_b: got %b required 0", bus_b.busy); end
    endtask

    task automatic test_basic();
        int k;
        k = cyc;
        qa.push_back(k + 14);
        qb.push_back(k + 10);
        rst = 1'b0;
        step(1);
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL basic_arm_busy: got %b required 1", bus_a.busy); end
        n_cmp++; if (bus_a.remaining !== 13'd0) begin n_bad++; $display("FAIL basic_arm_rem: got %0d required 0", bus_a.remaining); end
        step(1);
        n_cmp++; if (bus_a.remaining !== 13'd3) begin n_bad++; $display("FAIL basic_load_a: got %0d required 3", bus_a.remaining); end
        n_cmp++; if (bus_b.remaining !== 13'd4) begin n_bad++; $display("FAIL basic_load_b: got %0d required 4", bus_b.remaining); end
        for (int j = 1; j <= 3; j++) begin
            step(4);
            n_cmp++;
            if (bus_a.remaining !== 13'(3 - j)) begin
                n_bad++;
                $display("FAIL basic_step%0d: got %0d required %0d", j, bus_a.remaining, 3 - j);
            end
        end
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL basic_done_busy: got %b required 0", bus_a.busy); end
        step(5);
        n_cmp++; if (bus_a.remaining !== 13'd0) begin n_bad++; $display("FAIL basic_hold_rem: got %0d required 0", bus_a.remaining); end
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL basic_hold_busy: got %b required 0", bus_a.busy); end
        wait_drain(20);
    endtask

    task automatic test_restart();
        int m;
        m = cyc;
        bus_a.present_state = 4'd1;
        step(1);
        bus_a.tload = 13'd5;
        step(1);
        n_cmp++; if (bus_a.remaining !== 13'd5) begin n_bad++; $display("FAIL restart_load5: got %0d required 5", bus_a.remaining); end
        step(12);
        n_cmp++; if (bus_a.remaining !== 13'd2) begin n_bad++; $display("FAIL restart_at2: got %0d required 2", bus_a.remaining); end
        step(1);
        bus_a.present_state = 4'd3;
        step(1);
        n_cmp++; if (bus_a.remaining !== 13'd2) begin n_bad++; $display("FAIL restart_arm_rem: got %0d required 2", bus_a.remaining); end
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL restart_arm_busy: got %b required 1", bus_a.busy); end
        bus_a.tload = 13'd7;
        step(1);
        qa.push_back(m + 17 + 28);
        n_cmp++; if (bus_a.remaining !== 13'd7) begin n_bad++; $display("FAIL restart_load7: got %0d required 7", bus_a.remaining); end
        step(3);
        n_cmp++; if (bus_a.remaining !== 13'd7) begin n_bad++; $display("FAIL restart_presc0: got %0d required 7", bus_a.remaining); end
        step(1);
        n_cmp++; if (bus_a.remaining !== 13'd6) begin n_bad++; $display("FAIL restart_first_dec: got %0d required 6", bus_a.remaining); end
        wait_drain(60);
    endtask

    task automatic test_pause();
        int m;
        m = cyc;
        bus_b.present_state = 4'd2;
        step(1);
        bus_b.tload = 13'd4;
        step(1);
        n_cmp++; if (bus_b.remaining !== 13'd4) begin n_bad++; $display("FAIL pause_load: got %0d required 4", bus_b.remaining); end
        step(2);
        n_cmp++; if (bus_b.remaining !== 13'd3) begin n_bad++; $display("FAIL pause_before: got %0d required 3", bus_b.remaining); end
        qb.push_back(m + 20);
        bus_b.pause = 1'b1;
        step(10);
        n_cmp++; if (bus_b.remaining !== 13'd3) begin n_bad++; $display("FAIL pause_frozen: got %0d required 3", bus_b.remaining); end
        n_cmp++; if (bus_b.busy !== 1'b1) begin n_bad++; $display("FAIL pause_busy: got %b required 1", bus_b.busy); end
        bus_b.pause = 1'b0;
        wait_drain(30);
    endtask

    task automatic test_zero();
        int m;
        m = cyc;
        bus_a.present_state = 4'd5;
        qa.push_back(m + 2);
        step(1);
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL zero_arm_busy: got %b required 1", bus_a.busy); end
        bus_a.tload = 13'd0;
        step(1);
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL zero_done_busy: got %b required 0", bus_a.busy); end
        n_cmp++; if (bus_a.expired !== 1'b1) begin n_bad++; $display("FAIL zero_pulse: got %b required 1", bus_a.expired); end
        step(2);
        n_cmp++; if (bus_a.expired !== 1'b0) begin n_bad++; $display("FAIL zero_single: got %b required 0", bus_a.expired); end
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL zero_after_busy: got %b required 0", bus_a.busy); end
        wait_drain(10);
    endtask

    task automatic test_collide_and_reset();
        int m, k;
        m = cyc;
        bus_a.present_state = 4'd6;
        step(1);
        bus_a.tload = 13'd1;
        step(1);
        n_cmp++; if (bus_a.remaining !== 13'd1) begin n_bad++; $display("FAIL collide_load: got %0d required 1", bus_a.remaining); end
        step(3);
        bus_a.present_state = 4'd7;
        step(1);
        n_cmp++; if (bus_a.expired !== 1'b0) begin n_bad++; $display("FAIL collide_suppress: got %b required 0", bus_a.expired); end
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL collide_arm: got %b required 1", bus_a.busy); end
        n_cmp++; if (bus_a.remaining !== 13'd1) begin n_bad++; $display("FAIL collide_rem: got %0d required 1", bus_a.remaining); end
        bus_a.tload = 13'd3;
        step(1);
        n_cmp++; if (bus_a.remaining !== 13'd3) begin n_bad++; $display("FAIL rst_pre_rem: got %0d required 3", bus_a.remaining); end
        step(1);
        rst = 1'b1;
        step(1);
        n_cmp++; if (bus_a.remaining !== 13'd0) begin n_bad++; $display("FAIL rst_rem: got %0d required 0", bus_a.remaining); end
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", bus_a.busy); end
        n_cmp++; if (bus_a.expired !== 1'b0) begin n_bad++; $display("FAIL rst_exp: got %b required 0", bus_a.expired); end
        k = cyc;
        qa.push_back(k + 14);
        qb.push_back(k + 10);
        rst = 1'b0;
        step(1);
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL rst_rearm_busy: got %b required 1", bus_a.busy); end
        n_cmp++; if (bus_a.remaining !== 13'd0) begin n_bad++; $display("FAIL rst_rearm_rem: got %0d required 0", bus_a.remaining); end
        step(1);
        n_cmp++; if (bus_a.remaining !== 13'd3) begin n_bad++; $display("FAIL rst_reload: got %0d required 3", bus_a.remaining); end
        wait_drain(30);
    endtask

    task automatic test_autoreload();
        int k;
        k = cyc;
        bus_a.tload = 13'd3;
        bus_b.tload = 13'd2;
        for (int e = k + 6; e <= k + 60; e += 5) qb.push_back(e);
        for (int e = k + 14; e <= k + 60; e += 13) qa.push_back(e);
        rst = 1'b0;
        step(60);
        rst = 1'b1;
        step(2);
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL autoreload_pending: a=%0d b=%0d, required 0/0", qa.size(), qb.size());
        end
        n_cmp++; if (bus_b.remaining !== 13'd0) begin n_bad++; $display("FAIL autoreload_rst: got %0d required 0", bus_b.remaining); end
    endtask

    initial begin
        bus_a.present_state = 4'd0; bus_a.tload = 13'd0; bus_a.pause = 1'b0;
        bus_b.present_state = 4'd0; bus_b.tload = 13'd0; bus_b.pause = 1'b0;
        test_reset();
`ifdef TRAIN_TIMER_AUTORELOAD_EN
        test_autoreload();
`else
        test_basic();
        test_restart();
        test_pause();
        test_zero();
        test_collide_and_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
